// File: rtl/api_txarb.sv
// api_txarb: round-robin arbiter that moves fixed-length bursts from two requesters into a TX FIFO.
// Bursts abandoned early are zero-padded so the FIFO only ever holds whole bursts.
module api_txarb #(
    parameter int FIFO_DEPTH = 1024,
    parameter int CNT_W      = 11
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             flush,
    input  logic [7:0]       word_num,
    input  logic [CNT_W-1:0] txcnt,
    input  logic             req0,
    input  logic             req1,
    input  logic             vld0,
    input  logic             vld1,
    input  logic [31:0]      din0,
    input  logic [31:0]      din1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rdy0,
    output logic             rdy1,
    output logic             txfifo_push,
    output logic [31:0]      txfifo_din,
    output logic             busy,
    output logic             burst_done,
    output logic             pad_err
);
    typedef enum logic [1:0] {IDLE, XFER, PAD, GAP} state_t;
    localparam logic [CNT_W:0] DEPTH = (CNT_W+1)'(FIFO_DEPTH);
    state_t state, state_nx;
    logic [CNT_W:0] space;
    logic [7:0] len, cnt;
    logic last_gnt, pick, grant, acc, fill, last, abort;
    assign space = DEPTH - {1'b0, txcnt};
    assign grant = (state == IDLE) && (req0 || req1) && (word_num != 8'd0)
                   && (space >= (CNT_W+1)'(word_num));
    // with both requesting, the one not served last wins; a lone requester always wins
    assign pick  = (req0 && req1) ? ~last_gnt : req1;
    assign acc   = (gnt0 && vld0) || (gnt1 && vld1);
    assign fill  = acc || (state == PAD);
    assign last  = (cnt + 8'd1) == len;
    assign abort = (state == XFER) && !acc && !(gnt1 ? req1 : req0);
    assign rdy0  = gnt0;
    assign rdy1  = gnt1;
    assign busy  = state != IDLE;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = grant ? XFER : IDLE;
            XFER:    state_nx = (acc && last) ? GAP : abort ? PAD : XFER;
            PAD:     state_nx = last ? GAP : PAD;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge CLK_I or posedge RST_I)
        if (RST_I) state <= IDLE;
        else       state <= flush ? IDLE : state_nx;
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            {gnt0, gnt1, txfifo_push, burst_done, pad_err} <= '0;
            len        <= '0;
            cnt        <= '0;
            txfifo_din <= '0;
            last_gnt   <= 1'b1;
        end else if (flush) begin
            {gnt0, gnt1, txfifo_push, burst_done, pad_err} <= '0;
            len        <= '0;
            cnt        <= '0;
            txfifo_din <= '0;
            last_gnt   <= 1'b1;
        end else begin
            txfifo_push <= fill;
            txfifo_din  <= acc ? (gnt1 ? din1 : din0) : 32'd0;
            burst_done  <= fill && last;
            pad_err     <= abort;
            if (grant) begin
                {gnt1, gnt0} <= pick ? 2'b10 : 2'b01;
                last_gnt     <= pick;
                len          <= word_num;
                cnt          <= '0;
            end else if (fill) begin
                cnt <= cnt + 8'd1;
            end
            if ((acc && last) || abort) {gnt1, gnt0} <= 2'b00;
        end
    end
endmodule

// File: doc/api_txarb.md
API_TXARB -- requirements
Module: api_txarb

Interface
REQ-001 Parameter FIFO_DEPTH, default 1024, is the TX FIFO capacity in 32-bit words.
REQ-002 Parameter CNT_W, default 11, is the width of the TX FIFO data count.
REQ-003 Port CLK_I, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port RST_I, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port flush, input, 1 bit: synchronous abort and clear, same effect as reset.
REQ-006 Port word_num, input, 8 bits: burst length in words; 0 disables granting.
REQ-007 Port txcnt, input, CNT_W bits: TX FIFO data count.
REQ-008 Ports req0 and req1, input, 1 bit each: requester wants to send one burst.
REQ-009 Ports vld0 and vld1, input, 1 bit each: requester data word valid.
REQ-010 Ports din0 and din1, input, 32 bits each: requester data word.
REQ-011 Ports gnt0 and gnt1, output, 1 bit each: requester owns the FIFO write port.
REQ-012 Ports rdy0 and rdy1, output, 1 bit each: word accepted when vldN and rdyN are both high.
REQ-013 Port txfifo_push, output, 1 bit: registered TX FIFO write enable.
REQ-014 Port txfifo_din, output, 32 bits: registered TX FIFO write data.
REQ-015 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 Port burst_done, output, 1 bit: one-cycle pulse when the last word of a burst is pushed.
REQ-017 Port pad_err, output, 1 bit: one-cycle pulse when a burst is aborted and zero-padded.

Function
REQ-018 The block has four states: IDLE, XFER, PAD and GAP; the state encoding is free.
REQ-019 space is computed as FIFO_DEPTH minus txcnt, in CNT_W+1 bits, unsigned.
REQ-020 In IDLE, a grant is issued when all of the following hold:
- (req0 or req1) is high,
- word_num is not 0,
- space is greater than or equal to word_num.
REQ-021 Arbitration is round-robin:
- the requester not granted last wins;
- a single active requester always wins;
- last-grant resets to 1, so req0 wins first.
REQ-022 On a grant:
- state goes to XFER on the next edge;
- gntN rises on that edge;
- word_num is latched into len;
- the word counter cnt is cleared.
REQ-023 In XFER:
- rdyN equals gntN;
- the non-granted rdy and gnt stay 0.
REQ-024 Each accepted word is registered: txfifo_push=1 and txfifo_din=dinN on the following cycle, so latency is 1; cnt increments.
REQ-025 When accepted word number len is reached:
- gnt and rdy drop on the next edge;
- state goes to GAP;
- burst_done pulses together with the final txfifo_push.
REQ-026 If the granted reqN is low in XFER with no word accepted that cycle and cnt < len:
- state goes to PAD;
- gnt and rdy drop;
- pad_err pulses once.
REQ-027 In PAD:
- one zero word is pushed per cycle until cnt equals len;
- burst_done pulses with the final pad push;
- state then goes to GAP.
REQ-028 GAP lasts exactly one cycle, then state goes to IDLE, so txcnt reflects the last push before the next space check.
REQ-029 Space is checked only at grant time. No push occurs while txcnt is at or above FIFO_DEPTH, because each grant guarantees room for the whole burst.
REQ-030 Changes to word_num during a burst are ignored until the next grant.
REQ-031 req high in XFER after the final word does not extend the burst; a new grant requires IDLE.
REQ-032 At most one txfifo_push per cycle; bursts are never interleaved between requesters.

Reset
REQ-033 On RST_I high (asynchronous), or on flush high at an edge:
- state becomes IDLE;
- cnt, len, gnt0, gnt1, rdy0, rdy1, txfifo_push, burst_done, pad_err and busy become 0;
- txfifo_din becomes 0;
- last-grant becomes 1.
REQ-034 A flush or reset mid-burst discards the burst without padding; pushes already registered are not retracted.
REQ-035 After reset deasserts, the earliest grant is on the first edge that meets REQ-020.

Verification
REQ-036 The bench shall cover the following directed scenarios:
- Single burst: word_num=23, txcnt=0, req0 and vld0 held high with an incrementing din. Required: gnt0 one cycle after req; 23 pushes of data 0..22; burst_done on push 23; busy back to 0 after GAP.
- Round-robin: req0 and req1 continuously high, word_num=4. Required: grants alternate 0,1,0,1; each burst is 4 contiguous pushes; no interleave.
- Space limit: txcnt=1010, word_num=23 → no grant. Then txcnt=1001 → grant on the next edge.
- Abort and pad: req1 drops after 5 of 8 words. Required: pad_err pulses once; 3 zero words pushed; burst_done on the 8th push.
- Flush mid-burst: flush at word 10 of 23. Required: next cycle is IDLE with all outputs 0, no padding, and 10 pushes total.
- Disable: word_num=0 with req0 high → no grant for 100 cycles. Then word_num=2 → grant.
